ram_arbiter: RTL and testbench

- Shares one single-port sync_ram instance, such as the data_ram wrapper, between two requesters: m0 (CPU load/store unit) and m1 (debug/DMA loader).
- Grants at most one access per cycle.
- Steers the RAM's 1-cycle registered read data back to the granted requester with a response-valid pulse.
- Arbitration mode: round-robin, or fixed-priority with starvation guard.

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/arb2_pick.sv | 15 +
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter
package ram_arb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 8;
  typedef enum logic {OWN_M0, OWN_M1} owner_e;
  typedef struct packed {
    logic [DATA_W/8-1:0] we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } ram_req_t;
endpackage

// File: rtl/arb2_pick.sv
// arb2_pick: one-hot two-way grant selection for round-robin or fixed priority
module arb2_pick (
  input  logic [1:0] req,
  input  logic       prio_fixed,
  input  logic       last_gnt,
  input  logic       starve,
  output logic [1:0] gnt
);
  logic pick_m1;
  // On a conflict m1 wins when starved (fixed) or when m0 went last (round-robin)
  always_comb begin
    pick_m1 = prio_fixed ? starve : !last_gnt;
    gnt = (&req) ? {pick_m1, !pick_m1} : req;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port sync RAM between two requesters
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_WAIT   = 8,
  localparam int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prio_fixed,
  input  logic                  m0_req,
  input  logic [NUM_BYTES-1:0]  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [NUM_BYTES-1:0]  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic [NUM_BYTES-1:0]  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  logic [1:0]        gnt;
  owner_e            last_gnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;
  logic              rsp_valid;
  owner_e            rsp_owner;

  assign starve = wait_cnt == WAIT_W'(MAX_WAIT);

  arb2_pick u_pick (
    .req       ({m1_req, m0_req} & {2{!rst}}),
    .prio_fixed(prio_fixed),
    .last_gnt  (last_gnt == OWN_M1),
    .starve    (starve),
    .gnt       (gnt)
  );

  // Steer the granted port onto the RAM and gate read data back to its owner
  always_comb begin
    m0_gnt    = gnt[0];
    m1_gnt    = gnt[1];
    ram_en    = |gnt;
    ram_we    = gnt[0] ? m0_we    : gnt[1] ? m1_we    : '0;
    ram_addr  = gnt[0] ? m0_addr  : gnt[1] ? m1_addr  : '0;
    ram_wdata = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : '0;
    m0_rvalid = !rst && rsp_valid && rsp_owner == OWN_M0;
    m1_rvalid = !rst && rsp_valid && rsp_owner == OWN_M1;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end

  // Remember the most recent winner; reset favours m0 on the first conflict
  always_ff @(posedge clk) begin
    if (rst) last_gnt <= OWN_M1;
    else if (ram_en) last_gnt <= gnt[1] ? OWN_M1 : OWN_M0;
  end

  // Count cycles m1 is kept waiting in fixed mode, saturating at the force point
  always_ff @(posedge clk) begin
    if (rst || !prio_fixed || !m1_req || gnt[1]) wait_cnt <= '0;
    else if (!starve) wait_cnt <= wait_cnt + 1'b1;
  end

  // Track which port owns the read data the RAM returns next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_owner <= OWN_M0;
    end else begin
      rsp_valid <= ram_en && ram_we == '0;
      rsp_owner <= gnt[1] ? OWN_M1 : OWN_M0;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized self-checking bench for ram_arbiter
module tb_ram_arbiter;
  localparam int MW = 3;

  logic        clk = 0, rst = 1, prio_fixed = 0;
  logic        m0_req = 0, m1_req = 0;
  logic [3:0]  m0_we = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_en;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;
  logic [15:0] ram_addr;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  int checks = 0, failures = 0;

  int          mlast = 1, mwait = 0, rsp_own = 0, e_w;
  bit          rsp_pend = 0, ev0, ev1;
  logic [31:0] rsp_data = 0, e_wd;
  logic [3:0]  e_we;
  logic [15:0] e_a;
  logic        g0, g1;

  ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .prio_fixed(prio_fixed),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read and byte-enable writes
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: winner from the arbitration rules, reads answered from a model memory
  always @(negedge clk) begin
    if (rst) e_w = -1;
    else if (m0_req && m1_req) e_w = prio_fixed ? (mwait == MW ? 1 : 0) : (mlast == 1 ? 0 : 1);
    else e_w = m0_req ? 0 : m1_req ? 1 : -1;
    e_we = e_w == 0 ? m0_we    : e_w == 1 ? m1_we    : 4'h0;
    e_a  = e_w == 0 ? m0_addr  : e_w == 1 ? m1_addr  : 16'h0;
    e_wd = e_w == 0 ? m0_wdata : e_w == 1 ? m1_wdata : 32'h0;
    ev0 = !rst && rsp_pend && rsp_own == 0;
    ev1 = !rst && rsp_pend && rsp_own == 1;
    chk("m0_gnt", m0_gnt, e_w == 0);
    chk("m1_gnt", m1_gnt, e_w == 1);
    chk("ram_en", ram_en, e_w >= 0);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_a);
    chk("ram_wdata", ram_wdata, e_wd);
    chk("m0_rvalid", m0_rvalid, ev0);
    chk("m1_rvalid", m1_rvalid, ev1);
    chk("m0_rdata", m0_rdata, ev0 ? rsp_data : 32'h0);
    chk("m1_rdata", m1_rdata, ev1 ? rsp_data : 32'h0);
    if (rst) begin
      mlast = 1;
      mwait = 0;
      rsp_pend = 0;
    end else begin
      mwait = (!prio_fixed || !m1_req || e_w == 1) ? 0 : (mwait < MW ? mwait + 1 : MW);
      rsp_pend = e_w >= 0 && e_we == 4'h0;
      if (e_w >= 0) begin
        mlast = e_w;
        rsp_own = e_w;
        rsp_data = ref_mem[e_a];
        for (int b = 0; b < 4; b++)
          if (e_we[b]) ref_mem[e_a][8*b +: 8] = e_wd[8*b +: 8];
      end
    end
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 32'hAAAA0000 | 32'(a);
      ref_mem[a] = 32'hAAAA0000 | 32'(a);
    end
    rst = 1;
    m0_req = 1;
    m1_req = 1;
    cyc();
    cyc();
    @(negedge clk);
    chk("reset_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("reset_en", ram_en, 1'b0);
    chk("reset_we", ram_we, 4'h0);
    chk("reset_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("reset_rdata", m0_rdata, 32'h0);

    // Round-robin alternation on a permanent conflict
    cyc();
    rst = 0;
    m0_addr = 16'h0010;
    m1_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("rr_rvalid", {m1_rvalid, m0_rvalid}, (i % 2) ? 2'b01 : 2'b10);
        chk("rr_rdata", (i % 2) ? m0_rdata : m1_rdata, (i % 2) ? 32'hAAAA0010 : 32'hAAAA0020);
      end
      cyc();
    end
    m0_req = 0;
    m1_req = 0;
    @(negedge clk);
    chk("rr_last_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
    chk("rr_last_rdata", m1_rdata, 32'hAAAA0020);

    // Full write, partial write, read back merged word
    cyc();
    m0_req = 1;
    m0_we = 4'hF;
    m0_addr = 16'h0100;
    m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_gnt", m0_gnt, 1'b1);
    cyc();
    m0_we = 4'b0010;
    m0_wdata = 32'h00005500;
    @(negedge clk);
    chk("wr2_ram_we", ram_we, 4'b0010);
    cyc();
    m0_we = 4'h0;
    @(negedge clk);
    chk("wr_no_rvalid", m0_rvalid, 1'b0);
    cyc();
    m0_req = 0;
    @(negedge clk);
    chk("rd_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
    chk("rd_rdata", m0_rdata, 32'hDEAD55EF);

    // Fixed priority with starvation guard
    cyc();
    prio_fixed = 1;
    m0_req = 1;
    m0_addr = 16'h0010;
    m1_req = 1;
    m1_addr = 16'h0020;
    m1_we = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("starve_gnt", {m1_gnt, m0_gnt}, (i == 3 || i == 7) ? 2'b10 : 2'b01);
      cyc();
    end

    // Solo requester streaming reads
    prio_fixed = 0;
    m0_req = 0;
    m1_addr = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("solo_gnt", m1_gnt, 1'b1);
      if (i > 0) begin
        chk("solo_rvalid", m1_rvalid, 1'b1);
        chk("solo_rdata", m1_rdata, 32'hAAAA0005 + 32'(i - 1));
      end
      cyc();
      m1_addr = 16'(6 + i);
    end
    m1_req = 0;
    @(negedge clk);
    chk("solo_last_rdata", m1_rdata, 32'hAAAA0007);
    chk("solo_idle_en", ram_en, 1'b0);

    // Reset arriving one cycle after a granted read
    cyc();
    m0_req = 1;
    m0_addr = 16'h0010;
    @(negedge clk);
    chk("rst_read_gnt", m0_gnt, 1'b1);
    cyc();
    rst = 1;
    m0_req = 0;
    @(negedge clk);
    chk("rst_read_rvalid", m0_rvalid, 1'b0);
    cyc();
    rst = 0;
    m0_req = 1;
    m1_req = 1;
    @(negedge clk);
    chk("post_rst_gnt", {m1_gnt, m0_gnt}, 2'b01);
    cyc();
    m0_req = 0;
    m1_req = 0;

    // Randomized traffic with held requests, mode flips and occasional reset
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      cyc();
      rst = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 49) == 0) prio_fixed = ~prio_fixed;
      if (!m0_req || g0) begin
        m0_req = $urandom_range(0, 2) != 0;
        m0_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        m0_addr = 16'($urandom_range(0, 15));
        m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req = $urandom_range(0, 2) != 0;
        m1_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        m1_addr = 16'($urandom_range(0, 15));
        m1_wdata = $urandom;
      end
    end
    cyc();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
